// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
// Holds the default datapath widths, the immediate-extension encodings and the zero-register index.
package cpu_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int REG_ZERO       = 0;

  typedef enum logic [1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_UPPER = 2'b10,
    EXT_RSVD  = 2'b11
  } ext_op_e;

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extender.
// Shared by the operand stage and the branch-target adder.
module imm_extend
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [15:0]       imm16,
  input  logic [1:0]        ext_op,
  output logic [DATA_W-1:0] imm_ext
);

  // NOTE: default assignment first so every path drives imm_ext and no latch is inferred.
  always_comb begin
    imm_ext = '0;
    case (ext_op_e'(ext_op))
      EXT_ZERO:  imm_ext[15:0]  = imm16;
      EXT_SIGN:  imm_ext        = {{(DATA_W-16){imm16[15]}}, imm16};
      EXT_UPPER: imm_ext[31:16] = imm16;
      default:   imm_ext        = '0;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// Operand stage: 2-read/1-write register file with a hardwired zero register,
// an optional write-to-read bypass and the immediate extender.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [15:0]       imm16,
  input  logic [1:0]        ext_op,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] imm_ext
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  // Entry 0 has no storage; it is synthesised as a constant zero on the read side.
  logic [DATA_W-1:0] mem [1:NREGS-1];

  logic wr_ok;
  assign wr_ok = we && (wa != ZERO_IDX);

  // NOTE: the array must be cleared asynchronously, so it is built from flops with a
  // reset loop rather than a RAM macro; state updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] val;
    val = '0;
    if (rst_n && ra != ZERO_IDX) begin
      if (BYPASS && wr_ok && wa == ra) val = wd;
      else                             val = mem[ra];
    end
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

  imm_extend #(.DATA_W(DATA_W)) u_imm_extend (
    .imm16   (imm16),
    .ext_op  (ext_op),
    .imm_ext (imm_ext)
  );

endmodule
